// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD bus receiver.
// Pure declarations: no latency or backpressure of its own.
package lcd_pkg;

  typedef enum logic [1:0] {
    INIT8  = 2'd0,
    NIB_HI = 2'd1,
    NIB_LO = 2'd2
  } lcd_state_t;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_ENTRY = 8'h04;
  localparam logic [7:0] CMD_FUNC  = 8'h20;
  localparam logic [7:0] CMD_DDRAM = 8'h80;

  // DDRAM address counter wraps modulo 128 in both directions.
  function automatic logic [6:0] step_addr(input logic [6:0] addr, input logic inc);
    return inc ? addr + 7'd1 : addr - 7'd1;
  endfunction

endpackage

// File: rtl/lcd_busy_timer.sv
// Loadable down-counter modelling the LCD busy window.
// Latency: busy rises the cycle after load; no backpressure, load always wins.
// Backpressure: none, the counter simply restarts on every load.
module lcd_busy_timer #(
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             busy
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/lcd_nibble_receiver.sv
// Receiving end of the processor's character-LCD bus: init tracking, nibble assembly, command decode.
// Latency: all outputs update one clk after the registered strobe sample.
// Backpressure: none; strobes arriving inside the busy window are processed and flagged timing_err.
module lcd_nibble_receiver
  import lcd_pkg::*;
#(
  parameter int BUSY_CYC = 2000,
  parameter int CLR_CYC  = 82000,
  parameter int CNT_W    = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sf_e,
  input  logic       e,
  input  logic       rs,
  input  logic       rw,
  input  logic       d,
  input  logic       c,
  input  logic       b,
  input  logic       a,
  output logic       mode_4bit,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_rs,
  output logic       char_we,
  output logic [6:0] char_addr,
  output logic [7:0] char_data,
  output logic       clear_pulse,
  output logic [6:0] ddram_addr,
  output logic       busy,
  output logic       proto_err,
  output logic       timing_err
);

  // Bus samples; strobe is taken on the registered falling edge of e.
  logic       smp_sfe, smp_e, smp_e_prev, smp_rs, smp_rw;
  logic [3:0] smp_nib;
  logic       strobe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_sfe    <= 1'b0;
      smp_e      <= 1'b0;
      smp_e_prev <= 1'b0;
      smp_rs     <= 1'b0;
      smp_rw     <= 1'b0;
      smp_nib    <= 4'h0;
    end else begin
      smp_sfe    <= sf_e;
      smp_e      <= e;
      smp_e_prev <= smp_e;
      smp_rs     <= rs;
      smp_rw     <= rw;
      smp_nib    <= {d, c, b, a};
    end
  end

  assign strobe = smp_sfe & ~smp_rw & ~smp_e & smp_e_prev;

  lcd_state_t       state_q, state_nx;
  logic             mode_nx, incr_q, incr_nx;
  logic [6:0]       addr_nx, char_addr_nx;
  logic [3:0]       hi_nib_q, hi_nib_nx;
  logic             hi_rs_q, hi_rs_nx;
  logic [7:0]       byte_nx, char_data_nx;
  logic             byte_rs_nx, have_byte;
  logic             bv_nx, we_nx, clr_nx, pe_nx, te_nx;
  logic             load;
  logic [CNT_W-1:0] load_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT8;
      mode_4bit   <= 1'b0;
      incr_q      <= 1'b1;
      ddram_addr  <= 7'h00;
      hi_nib_q    <= 4'h0;
      hi_rs_q     <= 1'b0;
      byte_valid  <= 1'b0;
      byte_data   <= 8'h00;
      byte_rs     <= 1'b0;
      char_we     <= 1'b0;
      char_addr   <= 7'h00;
      char_data   <= 8'h00;
      clear_pulse <= 1'b0;
      proto_err   <= 1'b0;
      timing_err  <= 1'b0;
    end else begin
      state_q     <= state_nx;
      mode_4bit   <= mode_nx;
      incr_q      <= incr_nx;
      ddram_addr  <= addr_nx;
      hi_nib_q    <= hi_nib_nx;
      hi_rs_q     <= hi_rs_nx;
      byte_valid  <= bv_nx;
      byte_data   <= byte_nx;
      byte_rs     <= byte_rs_nx;
      char_we     <= we_nx;
      char_addr   <= char_addr_nx;
      char_data   <= char_data_nx;
      clear_pulse <= clr_nx;
      proto_err   <= pe_nx;
      timing_err  <= te_nx;
    end
  end

  always_comb begin
    state_nx     = state_q;
    mode_nx      = mode_4bit;
    incr_nx      = incr_q;
    addr_nx      = ddram_addr;
    hi_nib_nx    = hi_nib_q;
    hi_rs_nx     = hi_rs_q;
    byte_nx      = byte_data;
    byte_rs_nx   = byte_rs;
    char_addr_nx = char_addr;
    char_data_nx = char_data;
    have_byte    = 1'b0;
    bv_nx        = 1'b0;
    we_nx        = 1'b0;
    clr_nx       = 1'b0;
    pe_nx        = 1'b0;
    te_nx        = 1'b0;
    load         = 1'b0;
    load_val     = CNT_W'(BUSY_CYC);

    if (strobe) begin
      te_nx = busy;
      case (state_q)
        INIT8: begin
          if (!smp_rs) begin
            have_byte  = 1'b1;
            byte_nx    = {smp_nib, 4'h0};
            byte_rs_nx = 1'b0;
          end
        end
        NIB_HI: begin
          hi_nib_nx = smp_nib;
          hi_rs_nx  = smp_rs;
          state_nx  = NIB_LO;
        end
        NIB_LO: begin
          state_nx = NIB_HI;
          if (smp_rs != hi_rs_q) begin
            pe_nx = 1'b1;
          end else begin
            have_byte  = 1'b1;
            byte_nx    = {hi_nib_q, smp_nib};
            byte_rs_nx = smp_rs;
          end
        end
        default: state_nx = INIT8;
      endcase

      if (have_byte) begin
        bv_nx = 1'b1;
        load  = 1'b1;
        if (byte_rs_nx) begin
          we_nx        = 1'b1;
          char_addr_nx = ddram_addr;
          char_data_nx = byte_nx;
          addr_nx      = step_addr(ddram_addr, incr_q);
        end else begin
          // Highest set bit selects the instruction.
          casez (byte_nx)
            8'b1???????: addr_nx = byte_nx[6:0];
            8'b001?????: begin
              if (byte_nx[4]) begin
                state_nx = INIT8;
                mode_nx  = 1'b0;
              end else if (state_q == INIT8) begin
                state_nx = NIB_HI;
                mode_nx  = 1'b1;
              end
            end
            8'b000001??: incr_nx = byte_nx[1];
            8'b0000001?: begin
              addr_nx  = 7'h00;
              load_val = CNT_W'(CLR_CYC);
            end
            8'b00000001: begin
              addr_nx  = 7'h00;
              incr_nx  = 1'b1;
              clr_nx   = 1'b1;
              load_val = CNT_W'(CLR_CYC);
            end
            default: ;
          endcase
        end
      end
    end
  end

  lcd_busy_timer #(.CNT_W(CNT_W)) u_busy (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .value (load_val),
    .busy  (busy)
  );

endmodule

// File: doc/lcd_nibble_receiver.md
Name: lcd_nibble_receiver

Overview:
- Synthesizable responder for the HD44780-style character-LCD bus that the processor drives on sf_e/e/rs/rw/d/c/b/a.
- Tracks the 8-bit and 4-bit init handshake, assembles nibbles into bytes, and decodes commands.
- Maintains the DDRAM address counter, emits character writes to a shadow display buffer and checks bus timing.
- Sits beside the processor in bench and on-chip self-check builds as the receiving end of its LCD writes.

Parameters:
- BUSY_CYC, 2000, clk cycles the LCD is busy after an ordinary byte (40 us at 50 MHz).
- CLR_CYC, 82000, clk cycles busy after clear (0x01) or home (0x02/0x03).
- CNT_W, 17, width of the busy counter; must hold CLR_CYC.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sf_e  in  1  1 = LCD owns the shared bus; bus ignored when 0
- e  in  1  LCD enable strobe; data latched on falling edge
- rs  in  1  0 = command, 1 = data
- rw  in  1  1 = read; reads ignored
- d,c,b,a  in  1 each  nibble bits DB7..DB4 (d = MSB)
- mode_4bit  out  1  4-bit interface active
- byte_valid  out  1  one-cycle pulse, byte assembled
- byte_data  out  8  assembled byte
- byte_rs  out  1  rs of assembled byte
- char_we  out  1  one-cycle pulse, data write
- char_addr  out  7  DDRAM address of the write
- char_data  out  8  character written
- clear_pulse  out  1  one-cycle pulse on clear-display command
- ddram_addr  out  7  current address counter
- busy  out  1  LCD busy window active
- proto_err  out  1  one-cycle pulse on rs mismatch between nibbles
- timing_err  out  1  one-cycle pulse when e falls while busy

Behaviour:
- Reset (async, rst_n=0):
  - state INIT8; mode_4bit=0; ddram_addr=0; increment=1.
  - Busy counter = 0; all pulse outputs 0.
  - byte_data=0, byte_rs=0, char_addr=0, char_data=0.
  - Reset mid-byte discards the held nibble.
- Sampling: e, rs, rw and the nibble are registered every clk.
- Strobe: a strobe is a sample with e=0 whose previous sample was 1, with sf_e=1 and rw=0 on that sample. Other falling edges are ignored.
- Latency: all outputs update one clk after the strobe sample.
- INIT8 state:
  - Each strobe with rs=0 is a full command: byte = {nibble, 4'h0}.
  - byte_valid fires for each such command.
  - Nibble 0x2 transitions to NIB_HI and sets mode_4bit=1.
  - rs=1 strobes in INIT8 are dropped with no pulse.
- NIB_HI state: store the nibble and its rs, go to NIB_LO. No output pulse.
- NIB_LO state:
  - byte = {hi, lo}; go to NIB_HI.
  - If rs differs from the stored rs: proto_err pulses, the byte is dropped, state goes to NIB_HI.
- Command decode (byte_rs=0), highest set bit wins:
  - 0x01: ddram_addr=0, increment=1, clear_pulse, busy=CLR_CYC.
  - 0x02/0x03: ddram_addr=0, busy=CLR_CYC.
  - 0x04-0x07: increment=bit1.
  - 0x08-0x0F: no effect on state.
  - 0x10-0x1F (cursor shift): no effect.
  - 0x20-0x3F: if bit4=1, return to INIT8 and clear mode_4bit.
  - 0x40-0x7F (CGRAM): ignored.
  - 0x80-0xFF: ddram_addr=byte[6:0].
- Data (byte_rs=1):
  - char_we pulses with char_addr=ddram_addr (pre-update) and char_data=byte.
  - Address then increments or decrements modulo 128 (0x7F→0x00, 0x00→0x7F).
- Busy:
  - Every accepted byte, including INIT8 commands, loads BUSY_CYC (or CLR_CYC).
  - busy=1 while the counter is nonzero.
- Timing error: a strobe arriving while busy=1 pulses timing_err. The nibble is still processed and reloads the counter.
- Simultaneous events: proto_err and timing_err may pulse in the same cycle.

Decomposition:
- Package lcd_pkg:
  - state enum {INIT8, NIB_HI, NIB_LO}.
  - Command constants CMD_CLEAR=8'h01, CMD_HOME=8'h02, CMD_ENTRY=8'h04, CMD_FUNC=8'h20, CMD_DDRAM=8'h80.
- Sub-module lcd_busy_timer: loadable down-counter with inputs load/value and output busy.

Test Plan:
- Init: nibbles 0x3,0x3,0x3,0x2 (rs=0), each spaced > BUSY_CYC → four byte_valid (0x30,0x30,0x30,0x20), then mode_4bit=1, no errors.
- 4-bit config: 0x28, 0x06, 0x0C, 0x01 → clear_pulse once, ddram_addr=0, busy held CLR_CYC cycles after the 0x01.
- Data: "H" = nibbles 0x4 then 0x8 (rs=1) → char_we with char_addr=0x00 and char_data=0x48; ddram_addr=0x01.
- Wrap and direction:
  - 0xFF, then data 0x41 → char_addr=0x7F, then ddram_addr=0x00.
  - 0x04, 0x80, then data → char_addr=0x00, then ddram_addr=0x7F.
- Errors:
  - High nibble rs=0 then low nibble rs=1 → proto_err, no byte_valid.
  - Strobe 10 cycles after a byte → timing_err.
  - sf_e=0 or rw=1 strobe → ignored.
- Reset mid-byte: rst_n low after the high nibble → INIT8, mode_4bit=0, ddram_addr=0, and the next 0x2 nibble is treated as an init command.
